ray_sphere_scan_worker: RTL and testbench
=========================================

// Module: ray_sphere_scan_worker
// PURPOSE
//  Next-generation per-row raytracing worker. For each of JOBS pixels in its stripe it tests the
//  ray against up to MAX_SPHERES spheres. Spheres are fetched from the shared scene table.
//  The worker keeps the nearest hit in front of the camera and writes that sphere's colour, or BG_COLOR
//  on a miss, to the line buffer through a write port. It sits between the job dispatcher
//  (start/done) and the line buffer. It generalises the old single-sphere worker with an
//  integer radius, a depth test and an abort input.
// PARAMETERS
//  PX_W        12    signed pixel coordinate width (x, y)
//  SP_W        16    signed sphere centre coordinate width
//  R_W         10    unsigned sphere radius width
//  COL_W       12    colour width (RGB444)
//  MAX_SPHERES 8     scene table depth; IDX_W = $clog2(MAX_SPHERES)
//  JOBS        16    pixels per activation; pixel j has x = pixel_start_x + j*N_WORKERS
//  N_WORKERS   40    worker count (x stride)
//  PX_Z        320   constant ray z component
//  BG_COLOR    12'h000  colour written on miss
// PORTS
//  clk           in   1        clock
//  rst_          in   1        asynchronous active-low reset
//  start         in   1        1-cycle request; accepted only when busy==0
//  abort         in   1        stop current work; the block is idle on the next cycle
//  pixel_start_x in   PX_W     signed first x of stripe (sampled on start)
//  pixel_y       in   PX_W     signed row y (sampled on start)
//  sph_count     in   IDX_W+1  active spheres 0..MAX_SPHERES (sampled on start)
//  sph_idx       out  IDX_W    scene table read address
//  sph_x/y/z     in   SP_W     signed centre; valid the cycle after sph_idx is set
//  sph_r         in   R_W      radius; valid the cycle after sph_idx is set
//  sph_color     in   COL_W    sphere colour; valid the cycle after sph_idx is set
//  busy          out  1        high from the cycle after start was accepted until done
//  done          out  1        1-cycle pulse after the last pixel write
//  px_we         out  1        1-cycle line buffer write strobe
//  px_addr       out  $clog2(JOBS)  job index j of the write
//  px_color      out  COL_W    colour of the write
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all internal regs 0.
//  FSM: IDLE -start-> SETUP -> FETCH -> CAPTURE -> MUL1 -> MUL2 -> DISC -> {SQRT -> CMP | FETCH | WRITE}.
//   Then CMP -> FETCH|WRITE and WRITE -> SETUP|DONE; DONE -> IDLE.
//  SETUP: px = pixel_start_x + j*N_WORKERS; clear best_valid; sphere index s = 0.
//   If sph_count==0, go directly to WRITE.
//  FETCH drives sph_idx = s. CAPTURE registers the sphere data.
//  Arithmetic is full-precision signed integer with no truncation or fixed point. Widths are derived
//   localparams sized so nothing overflows; DIS_W >= 2*(PX_W+SP_W)+6.
//   MUL1: px^2, py^2, px*sx, py*sy, PX_Z*sz, sx^2, sy^2, sz^2, r^2.
//   MUL2: a2 = 2*(px^2+py^2+PX_Z^2); b = 2*(px*sx+py*sy+PX_Z*sz);
//    c2 = 2*(sx^2+sy^2+sz^2-r^2).
//   DISC: dis = b^2 - a2*c2.
//    If dis<0: go to FETCH for the next sphere, or WRITE if this is the last sphere.
//  SQRT: iterative restoring integer sqrt, exactly DIS_W/2 cycles, floor result q.
//  CMP: t_num = b - q. Hit iff t_num > 0. No division is needed because a2 is common to all spheres.
//   Update the best hit if !best_valid or t_num < best_t (strict compare: on a tie the lower index wins).
//   Then s++, and go to FETCH if s < sph_count, else WRITE.
//  WRITE: px_we=1 for exactly one cycle, px_addr=j, px_color = best_valid ? best_color : BG_COLOR.
//   Then j++. Go to SETUP if j < JOBS, else DONE.
//  DONE: done=1 for one cycle, busy=0 from that same cycle, then IDLE.
//  start while busy or in DONE: ignored. Inputs are sampled only on accept.
//  abort: highest priority in any state. Next cycle: IDLE, busy=0, no px_we, no done, sqrt aborted.
//   abort and start in the same cycle: abort wins and start is dropped.
//  Mid-operation async reset: immediate return to reset values, with no partial writes afterwards.
//  Pixel latency per sphere: 6 cycles on a miss (dis<0); 7 + DIS_W/2 cycles on sqrt.
//  Writes occur in ascending j order with no gaps in addressing.
// TESTING
//  1 sph (0,0,640) r=100, px=py=0: a2=204800, b=409600, c2=799200, dis=4096000000, q=64000,
//    t_num=345600 -> hit, sphere colour written.
//  1 sph (1000,0,640) r=100, px=py=0: dis<0 -> BG_COLOR; check 6-cycle sphere path.
//  sph0 (0,0,1280) r=100 col A, sph1 (0,0,640) r=100 col B on axis -> B written (nearest);
//    identical spheres at idx0/idx1 -> idx0 colour (tie).
//  sph (0,0,-640) r=100: dis>0, t_num=-473600 -> BG_COLOR (behind camera).
//  sph_count=0, JOBS=16 -> 16 BG writes with addr 0..15, then one done pulse, busy drops with done.
//  abort during SQRT of pixel 3 -> IDLE next cycle, exactly 3 writes, no done;
//    a new start then runs the full stripe correctly.

Source files
------------

// File: rtl/ray_sphere_scan_worker.sv
// Per-row ray/sphere worker: for each pixel of its stripe, scans the scene
// table and writes the colour of the nearest sphere in front of the camera
// (or the background colour) to the line buffer.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start
// SETUP   | compute pixel x, clear best hit, rewind sphere index
// FETCH   | present sphere index to the scene table
// CAPTURE | register sphere centre, radius and colour
// MUL1    | first-level products
// MUL2    | a2, b, c2 sums
// DISC    | discriminant; negative means miss for this sphere
// SQRT    | restoring integer square root, DIS_W/2 cycles
// CMP     | nearest-hit update
// WRITE   | one line buffer write for pixel j
// DONE    | one-cycle done pulse
module ray_sphere_scan_worker #(
  parameter int PX_W        = 12,
  parameter int SP_W        = 16,
  parameter int R_W         = 10,
  parameter int COL_W       = 12,
  parameter int MAX_SPHERES = 8,
  parameter int JOBS        = 16,
  parameter int N_WORKERS   = 40,
  parameter int PX_Z        = 320,
  parameter logic [COL_W-1:0] BG_COLOR = '0,
  localparam int IDX_W      = $clog2(MAX_SPHERES),
  localparam int JW         = $clog2(JOBS)
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    start,
  input  logic                    abort,
  input  logic signed [PX_W-1:0]  pixel_start_x,
  input  logic signed [PX_W-1:0]  pixel_y,
  input  logic [IDX_W:0]          sph_count,
  output logic [IDX_W-1:0]        sph_idx,
  input  logic signed [SP_W-1:0]  sph_x,
  input  logic signed [SP_W-1:0]  sph_y,
  input  logic signed [SP_W-1:0]  sph_z,
  input  logic [R_W-1:0]          sph_r,
  input  logic [COL_W-1:0]        sph_color,
  output logic                    busy,
  output logic                    done,
  output logic                    px_we,
  output logic [JW-1:0]           px_addr,
  output logic [COL_W-1:0]        px_color
);

  // b^2 and a2*c2 both stay well inside this width, so the discriminant is exact.
  localparam int DIS_W = 2*(PX_W+SP_W)+6;
  localparam int HALF  = DIS_W/2;
  localparam int CW    = $clog2(HALF);
  localparam logic signed [DIS_W-1:0] NW  = DIS_W'(N_WORKERS);
  localparam logic signed [DIS_W-1:0] PZ  = DIS_W'(PX_Z);
  localparam logic signed [DIS_W-1:0] PZ2 = DIS_W'(PX_Z*PX_Z);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_FETCH, S_CAPTURE, S_MUL1, S_MUL2,
    S_DISC, S_SQRT, S_CMP, S_WRITE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [PX_W-1:0]  start_x_r;
  logic [IDX_W:0]          cnt_r, s_r, s_inc;
  logic [JW-1:0]           j_r;
  logic signed [DIS_W-1:0] px_r, py_r, sx_r, sy_r, sz_r, rr_r;
  logic signed [DIS_W-1:0] p_xx, p_yy, p_xs, p_ys, p_zs, p_sxx, p_syy, p_szz, p_rr;
  logic signed [DIS_W-1:0] a2_r, b_r, c2_r, dis_c, t_c, best_t;
  logic [COL_W-1:0]        col_r, best_color;
  logic                    best_valid, last_sph, hit;
  logic [DIS_W-1:0]        sq_val;
  logic [HALF+1:0]         sq_rem, rem_n, trial;
  logic [HALF-1:0]         sq_q;
  logic [CW-1:0]           sq_cnt;

  assign s_inc    = s_r + 1'b1;
  assign last_sph = (s_inc >= cnt_r);
  assign dis_c    = b_r*b_r - a2_r*c2_r;
  assign rem_n    = (sq_rem << 2) | (HALF+2)'(sq_val[DIS_W-1 -: 2]);
  assign trial    = {sq_q, 2'b01};
  // a2 > 0 is shared by every sphere, so t_num orders hits without a divide.
  assign t_c      = b_r - signed'(DIS_W'(sq_q));
  assign hit      = (t_c > 0);
  assign sph_idx  = s_r[IDX_W-1:0];
  assign px_addr  = j_r;

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and Moore outputs; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    px_we    = 1'b0;
    px_color = '0;
    case (state_q)
      S_IDLE:    if (start) state_d = S_SETUP;
      S_SETUP:   state_d = (cnt_r == '0) ? S_WRITE : S_FETCH;
      S_FETCH:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_MUL1;
      S_MUL1:    state_d = S_MUL2;
      S_MUL2:    state_d = S_DISC;
      S_DISC: begin
        if (dis_c[DIS_W-1]) state_d = last_sph ? S_WRITE : S_FETCH;
        else                state_d = S_SQRT;
      end
      S_SQRT:    if (sq_cnt == CW'(HALF-1)) state_d = S_CMP;
      S_CMP:     state_d = last_sph ? S_WRITE : S_FETCH;
      S_WRITE:   state_d = (j_r == JW'(JOBS-1)) ? S_DONE : S_SETUP;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
    busy = (state_q != S_IDLE) && (state_q != S_DONE);
    done = (state_q == S_DONE);
    if (state_q == S_WRITE) begin
      px_we    = 1'b1;
      px_color = best_valid ? best_color : BG_COLOR;
    end
  end

  // Datapath: job capture, per-sphere arithmetic, sqrt and nearest-hit tracking.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      start_x_r <= '0; cnt_r <= '0; s_r <= '0; j_r <= '0;
      px_r <= '0; py_r <= '0; sx_r <= '0; sy_r <= '0; sz_r <= '0; rr_r <= '0;
      p_xx <= '0; p_yy <= '0; p_xs <= '0; p_ys <= '0; p_zs <= '0;
      p_sxx <= '0; p_syy <= '0; p_szz <= '0; p_rr <= '0;
      a2_r <= '0; b_r <= '0; c2_r <= '0; best_t <= '0;
      col_r <= '0; best_color <= '0; best_valid <= 1'b0;
      sq_val <= '0; sq_rem <= '0; sq_q <= '0; sq_cnt <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start && !abort) begin
          start_x_r <= pixel_start_x;
          py_r      <= DIS_W'(pixel_y);
          cnt_r     <= sph_count;
          j_r       <= '0;
        end
        S_SETUP: begin
          px_r       <= DIS_W'(start_x_r) + signed'(DIS_W'(j_r)) * NW;
          best_valid <= 1'b0;
          s_r        <= '0;
        end
        S_CAPTURE: begin
          sx_r  <= DIS_W'(sph_x);
          sy_r  <= DIS_W'(sph_y);
          sz_r  <= DIS_W'(sph_z);
          rr_r  <= signed'(DIS_W'(sph_r));
          col_r <= sph_color;
        end
        S_MUL1: begin
          p_xx  <= px_r*px_r;  p_yy  <= py_r*py_r;
          p_xs  <= px_r*sx_r;  p_ys  <= py_r*sy_r;  p_zs <= PZ*sz_r;
          p_sxx <= sx_r*sx_r;  p_syy <= sy_r*sy_r;  p_szz <= sz_r*sz_r;
          p_rr  <= rr_r*rr_r;
        end
        S_MUL2: begin
          a2_r <= (p_xx + p_yy + PZ2) <<< 1;
          b_r  <= (p_xs + p_ys + p_zs) <<< 1;
          c2_r <= (p_sxx + p_syy + p_szz - p_rr) <<< 1;
        end
        S_DISC: begin
          sq_val <= dis_c;
          sq_rem <= '0;
          sq_q   <= '0;
          sq_cnt <= '0;
          if (dis_c[DIS_W-1]) s_r <= s_inc;
        end
        S_SQRT: begin
          sq_val <= sq_val << 2;
          sq_cnt <= sq_cnt + 1'b1;
          if (rem_n >= trial) begin
            sq_rem <= rem_n - trial;
            sq_q   <= {sq_q[HALF-2:0], 1'b1};
          end else begin
            sq_rem <= rem_n;
            sq_q   <= {sq_q[HALF-2:0], 1'b0};
          end
        end
        S_CMP: begin
          if (hit && (!best_valid || t_c < best_t)) begin
            best_valid <= 1'b1;
            best_t     <= t_c;
            best_color <= col_r;
          end
          s_r <= s_inc;
        end
        S_WRITE: if (j_r != JW'(JOBS-1)) j_r <= j_r + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_sphere_scan_worker.sv
// Directed bench for ray_sphere_scan_worker: table of scenes with hand-computed
// first-pixel colour and latency, full-stripe model check, plus abort/reset sequences.
module tb_ray_sphere_scan_worker;

  logic clk = 1'b0;
  logic rst_;
  logic start, abort;
  logic signed [11:0] pixel_start_x, pixel_y;
  logic [3:0]  sph_count;
  logic [2:0]  sph_idx;
  logic signed [15:0] sph_x, sph_y, sph_z;
  logic [9:0]  sph_r;
  logic [11:0] sph_color;
  logic busy, done, px_we;
  logic [3:0]  px_addr;
  logic [11:0] px_color;

  always #5 clk = ~clk;

  ray_sphere_scan_worker dut (
    .clk(clk), .rst_(rst_), .start(start), .abort(abort),
    .pixel_start_x(pixel_start_x), .pixel_y(pixel_y), .sph_count(sph_count),
    .sph_idx(sph_idx), .sph_x(sph_x), .sph_y(sph_y), .sph_z(sph_z),
    .sph_r(sph_r), .sph_color(sph_color), .busy(busy), .done(done),
    .px_we(px_we), .px_addr(px_addr), .px_color(px_color)
  );

  // Scene table with one-cycle read latency.
  logic signed [15:0] scn_x [8];
  logic signed [15:0] scn_y [8];
  logic signed [15:0] scn_z [8];
  logic [9:0]  scn_r [8];
  logic [11:0] scn_c [8];
  always @(posedge clk) begin
    sph_x <= scn_x[sph_idx]; sph_y <= scn_y[sph_idx]; sph_z <= scn_z[sph_idx];
    sph_r <= scn_r[sph_idx]; sph_color <= scn_c[sph_idx];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int wr_addr[$], wr_col[$], wr_cyc[$];
  int done_cnt, done_cyc, busy_at_done;
  always @(negedge clk) begin
    if (rst_ === 1'b1) begin
      if (px_we) begin
        wr_addr.push_back(int'(px_addr));
        wr_col.push_back(int'(px_color));
        wr_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy) busy_at_done++;
      end
    end
  end

  int n_pass = 0, n_total = 0, st_cyc;

  task automatic check(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick;
    @(negedge clk); #2;
  endtask

  function automatic longint isqrt(input longint v);
    longint q = 0;
    for (int k = 30; k >= 0; k--) begin
      longint t = q | (longint'(1) << k);
      if (t*t <= v) q = t;
    end
    return q;
  endfunction

  // Reference: nearest positive hit by exact integer arithmetic on the ray equation.
  function automatic int model_color(input int px, input int py, input int n);
    longint a2, b, c2, dis, q, t, bt;
    bit bv = 0;
    int bc = 0;
    bt = 0;
    for (int i = 0; i < n; i++) begin
      longint sx = longint'(scn_x[i]), sy = longint'(scn_y[i]), sz = longint'(scn_z[i]);
      longint r = longint'(scn_r[i]);
      a2 = 2*(longint'(px)*px + longint'(py)*py + 320*320);
      b  = 2*(longint'(px)*sx + longint'(py)*sy + 320*sz);
      c2 = 2*(sx*sx + sy*sy + sz*sz - r*r);
      dis = b*b - a2*c2;
      if (dis >= 0) begin
        q = isqrt(dis);
        t = b - q;
        if (t > 0 && (!bv || t < bt)) begin bv = 1; bt = t; bc = int'(scn_c[i]); end
      end
    end
    return bc;
  endfunction

  task automatic clear_log;
    wr_addr.delete(); wr_col.delete(); wr_cyc.delete();
    done_cnt = 0; busy_at_done = 0; done_cyc = 0;
  endtask

  // Runs one stripe; optionally pulses a start while busy that must be ignored.
  task automatic run_stripe(input int sx, input int y, input int n, input int inject);
    clear_log();
    pixel_start_x = 12'(sx); pixel_y = 12'(y); sph_count = 4'(n);
    start = 1'b1; st_cyc = cyc; tick; start = 1'b0;
    for (int k = 0; k < 6000 && done_cnt == 0; k++) begin
      if (k == inject) begin
        pixel_start_x = 12'(sx + 7); sph_count = 4'd0; start = 1'b1;
        tick; start = 1'b0;
      end else tick;
    end
    check("done_seen", (done_cnt > 0), 1);
    repeat (4) tick;
    check("n_writes", wr_addr.size(), 16);
    for (int i = 0; i < wr_addr.size() && i < 16; i++) begin
      check($sformatf("addr[%0d]", i), wr_addr[i], i);
      check($sformatf("color[%0d]", i), wr_col[i], model_color(sx + i*40, y, n));
    end
    check("done_pulses", done_cnt, 1);
    check("busy_low_at_done", busy_at_done, 0);
    if (wr_cyc.size() > 0) check("done_after_last_write", done_cyc - wr_cyc[$], 1);
  endtask

  typedef struct {
    int n;
    int x0, y0, z0, r0, c0;
    int x1, y1, z1, r1, c1;
    int start_x, y;
    int exp0;
    int lat0;
  } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{1, 0,0,640,100,'hABC,  0,0,0,0,0,        0, 0, 'hABC, 39};
    vecs[1] = '{1, 1000,0,640,100,'h9F1, 0,0,0,0,0,      0, 0, 'h000, 7};
    vecs[2] = '{2, 0,0,1280,100,'h111, 0,0,640,100,'h222, 0, 0, 'h222, 76};
    vecs[3] = '{2, 0,0,640,100,'h333,  0,0,640,100,'h444, 0, 0, 'h333, 76};
    vecs[4] = '{1, 0,0,-640,100,'hD0D, 0,0,0,0,0,        0, 0, 'h000, 39};
    vecs[5] = '{2, 0,0,640,100,'h555,  0,0,1280,100,'h666, 0, 0, 'h555, 76};
    vecs[6] = '{0, 0,0,640,100,'h777,  0,0,0,0,0,        0, 0, 'h000, 2};
    vecs[7] = '{1, 0,0,640,100,'hABC,  0,0,0,0,0,      -40, 0, 'hABC, 39};

    for (int i = 0; i < 8; i++) begin
      scn_x[i] = '0; scn_y[i] = '0; scn_z[i] = '0; scn_r[i] = '0; scn_c[i] = '0;
    end
    rst_ = 1'b0; start = 1'b0; abort = 1'b0;
    pixel_start_x = '0; pixel_y = '0; sph_count = '0;
    clear_log();
    repeat (3) tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_px_we", px_we, 0);
    check("rst_px_addr", px_addr, 0);
    check("rst_px_color", px_color, 0);
    check("rst_sph_idx", sph_idx, 0);
    rst_ = 1'b1;
    tick;

    for (int v = 0; v < 8; v++) begin
      scn_x[0] = 16'(vecs[v].x0); scn_y[0] = 16'(vecs[v].y0); scn_z[0] = 16'(vecs[v].z0);
      scn_r[0] = 10'(vecs[v].r0); scn_c[0] = 12'(vecs[v].c0);
      scn_x[1] = 16'(vecs[v].x1); scn_y[1] = 16'(vecs[v].y1); scn_z[1] = 16'(vecs[v].z1);
      scn_r[1] = 10'(vecs[v].r1); scn_c[1] = 12'(vecs[v].c1);
      run_stripe(vecs[v].start_x, vecs[v].y, vecs[v].n, (v == 0) ? 100 : -1);
      if (wr_col.size() > 0) begin
        check($sformatf("v%0d_pixel0_color", v), wr_col[0], vecs[v].exp0);
        check($sformatf("v%0d_pixel0_latency", v), wr_cyc[0] - st_cyc, vecs[v].lat0);
      end else check($sformatf("v%0d_pixel0_present", v), 0, 1);
    end

    // Abort during the sqrt of pixel 3, with a simultaneous start that must be dropped.
    scn_x[0] = 0; scn_y[0] = 0; scn_z[0] = 640; scn_r[0] = 10'd500; scn_c[0] = 12'h7A5;
    clear_log();
    pixel_start_x = '0; pixel_y = '0; sph_count = 4'd1;
    start = 1'b1; tick; start = 1'b0;
    for (int k = 0; k < 2000 && wr_addr.size() < 3; k++) tick;
    check("abort_prewrites", wr_addr.size(), 3);
    repeat (20) tick;
    check("abort_busy_before", busy, 1);
    abort = 1'b1; start = 1'b1; tick; abort = 1'b0; start = 1'b0;
    check("abort_busy_next", busy, 0);
    repeat (60) tick;
    check("abort_writes", wr_addr.size(), 3);
    check("abort_no_done", done_cnt, 0);
    check("abort_idle_busy", busy, 0);
    for (int i = 0; i < wr_addr.size(); i++)
      check($sformatf("abort_color[%0d]", i), wr_col[i], model_color(i*40, 0, 1));
    run_stripe(0, 0, 1, -1);

    // Asynchronous reset mid-stripe: no writes afterwards.
    clear_log();
    pixel_start_x = '0; pixel_y = '0; sph_count = 4'd1;
    start = 1'b1; tick; start = 1'b0;
    repeat (100) tick;
    rst_ = 1'b0; #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_px_addr", px_addr, 0);
    tick; rst_ = 1'b1;
    clear_log();
    repeat (60) tick;
    check("mid_rst_no_writes", wr_addr.size(), 0);
    check("mid_rst_no_done", done_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
